sdram_sim_model: RTL and testbench
==================================

Name: sdram_sim_model

Overview:
- Cycle-approximate behavioural model of a 32-bit SDRAM plus controller, used in simulation in place of the FPGA memory controller.
- It is driven by the memory-front-end FSM through a level request / stall handshake, supporting word reads, byte-masked word writes and refresh.
- Its backing store is a byte array that the enclosing wrapper preloads hierarchically with the boot image.

Parameters:
- MEM_SIZE, 32'h0001_0000: size of the backing store in bytes. Must be a power of two and a multiple of 4.
- READ_LAT, 4: cycles w_stall stays high for a read. Must be ≥1.
- WRITE_LAT, 4: cycles w_stall stays high for a write. Must be ≥1.
- REFRESH_LAT, 8: cycles w_stall stays high for a refresh. Must be ≥1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- w_addr  in  32  byte address. Bits [1:0] are ignored.
- w_le  in  1  read request (level).
- w_we  in  1  write request (level).
- w_refresh  in  1  refresh request (level).
- w_wdata  in  32  write data, little-endian.
- w_mask  in  4  byte enables, active-high. Bit i writes byte i = w_wdata[8i+7:8i].
- w_stall  out  1  busy flag.
- w_odata  out  32  read data.
- w_mtime  in  32  timestamp for debug messages only; has no functional effect.

Behaviour:
- Storage: internal byte array named mem[0:MEM_SIZE-1]. It is not cleared by reset; its initial content is X or the preloaded values.
- Word address: word base = {w_addr[31:2],2'b00} mod MEM_SIZE, so out-of-range addresses wrap. Byte i of a word lives at mem[base+i].
- States: IDLE, BUSY.
- Reset: async assertion forces IDLE, w_stall=0, w_odata=0.
  - Reset during BUSY aborts the operation. An aborted write leaves mem unchanged.
- Accept (IDLE only), at a rising edge where any request is high:
  - Priority is w_we > w_le > w_refresh.
  - Latch the operation type, word base, w_wdata and w_mask.
  - Load a counter with the matching LAT and enter BUSY. w_stall becomes 1 after this edge.
- BUSY:
  - All request inputs are ignored and w_stall=1.
  - The counter decrements each edge. On the edge where it would reach 0 the operation commits, w_stall drops to 0 and the state returns to IDLE.
  - Net effect: w_stall is high for exactly LAT consecutive cycles.
- Commit, read: w_odata <= {mem[b+3],mem[b+2],mem[b+1],mem[b]}. The value is held until the next read commit or reset.
- Commit, write: for each i with w_mask[i]=1, mem[b+i] <= wdata[8i+7:8i]. w_mask=0 is a legal no-op that still stalls for WRITE_LAT. w_odata is unchanged.
- Commit, refresh: no data effect. w_odata is unchanged.
- Back-to-back requests:
  - A request still asserted in the cycle after commit (state IDLE) is accepted again.
  - The requester must drop its request once it sees w_stall=1, which it does.
  - The minimum gap between operations is therefore 1 idle cycle.
- Read data is valid in the first cycle w_stall is 0 after BUSY. The requester samples it when it sees !w_stall.
- Simultaneous w_we and w_le: only the write is performed. The read is not queued; the requester must re-issue it.

Test Plan:
- Reset, then write addr 0x100, data 0xDEADBEEF, mask 4'hF, holding w_we until w_stall=1 -> w_stall high exactly WRITE_LAT cycles. Then read 0x100 -> w_odata=0xDEADBEEF when w_stall falls, w_stall high exactly READ_LAT cycles.
- Partial write to 0x100 with data 0x11223344, mask 4'b0101, then read -> 0xDE22BE44.
- Read of addr 0x103 -> same word as 0x100. Write to MEM_SIZE+0x100 then read 0x100 -> shows the wrapped data.
- Pulse w_refresh in IDLE -> w_stall high REFRESH_LAT cycles, w_odata unchanged. A w_le raised mid-refresh is ignored until IDLE, then accepted.
- Assert w_we and w_le together -> write executed, no read commit, w_odata unchanged.
- Async rst mid-write (cycle 2 of BUSY) -> w_stall=0 and w_odata=0 immediately; a later read shows the old memory value.

Source files
------------

// File: rtl/sdram_sim_model.sv
// ---------------------------------------------------------------------------
// sdram_sim_model
//
// Cycle-approximate behavioural stand-in for a 32-bit SDRAM and its
// controller. The memory front-end FSM uses it in simulation. Requests are
// level signals. The model answers with a busy flag that stays high for a
// fixed number of cycles per operation type. The backing store is a byte
// array named mem. The enclosing wrapper preloads it hierarchically with the
// boot image.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   w_addr     in   byte address; bits [1:0] ignored, wraps modulo MEM_SIZE
//   w_le       in   read request (level)
//   w_we       in   write request (level)
//   w_refresh  in   refresh request (level)
//   w_wdata    in   write data, little-endian
//   w_mask     in   byte enables, bit i enables w_wdata[8i+7:8i]
//   w_stall    out  busy flag, high for exactly <op>_LAT cycles per operation
//   w_odata    out  read data, held until the next read commit or reset
//   w_mtime    in   debug timestamp, no functional effect
// ---------------------------------------------------------------------------
module sdram_sim_model #(
  parameter int unsigned MEM_SIZE    = 32'h0001_0000,
  parameter int unsigned READ_LAT    = 4,
  parameter int unsigned WRITE_LAT   = 4,
  parameter int unsigned REFRESH_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] w_addr,
  input  logic        w_le,
  input  logic        w_we,
  input  logic        w_refresh,
  input  logic [31:0] w_wdata,
  input  logic [3:0]  w_mask,
  output logic        w_stall,
  output logic [31:0] w_odata,
  input  logic [31:0] w_mtime
);

  localparam int unsigned AW = $clog2(MEM_SIZE);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_REF = 2'd2;

  logic [7:0]    mem [0:MEM_SIZE-1];

  logic [0:0]    r_state;
  logic [1:0]    r_op;
  logic [31:0]   r_cnt;
  logic [AW-1:0] r_base;
  logic [31:0]   r_wdata;
  logic [3:0]    r_mask;

  logic          w_req_any;
  logic          w_last;
  logic          w_wr_commit;
  logic [AW-1:0] w_base_in;
  logic [31:0]   w_rd_word;
  logic          w_unused;

  assign w_req_any = w_we | w_le | w_refresh;

  // Truncating to AW bits gives the modulo-MEM_SIZE wrap. Clearing the
  // low two bits word-aligns the address.
  assign w_base_in = {w_addr[AW-1:2], 2'b00};

  // The busy countdown is on its final edge. The operation commits on this edge.
  assign w_last      = (r_state == BUSY) && (r_cnt == 32'd1);
  assign w_wr_commit = w_last && (r_op == OP_WR);

  assign w_rd_word = {mem[{r_base[AW-1:2], 2'd3}],
                      mem[{r_base[AW-1:2], 2'd2}],
                      mem[{r_base[AW-1:2], 2'd1}],
                      mem[{r_base[AW-1:2], 2'd0}]};

  // The debug timestamp and the ignored address bits are consumed only here.
  assign w_unused = ^{w_mtime, w_addr};

  // NOTE: state registers use non-blocking assignments. Every always_ff
  // block then sees the pre-edge values, whatever the evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_REF;
      r_cnt   <= 32'd0;
      r_base  <= '0;
      r_wdata <= 32'd0;
      r_mask  <= 4'd0;
      w_stall <= 1'b0;
      w_odata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_any) begin
            // Write beats read beats refresh. A read that loses is dropped,
            // not queued.
            if (w_we) begin
              r_op  <= OP_WR;
              r_cnt <= WRITE_LAT;
            end else if (w_le) begin
              r_op  <= OP_RD;
              r_cnt <= READ_LAT;
            end else begin
              r_op  <= OP_REF;
              r_cnt <= REFRESH_LAT;
            end
            r_base  <= w_base_in;
            r_wdata <= w_wdata;
            r_mask  <= w_mask;
            r_state <= BUSY;
            w_stall <= 1'b1;
          end
        end
        default: begin
          if (w_last) begin
            r_state <= IDLE;
            w_stall <= 1'b0;
            if (r_op == OP_RD) begin
              w_odata <= w_rd_word;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
      endcase
    end
  end

  // NOTE: the backing store is deliberately left out of the reset. It keeps
  // its preloaded image across resets. Resetting it would also prevent
  // RAM inference. A reset during BUSY returns r_state to IDLE
  // asynchronously, so w_wr_commit can never fire for an aborted write.
  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_mask[i]) begin
          mem[{r_base[AW-1:2], 2'(i)}] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_sim_model.sv
// ---------------------------------------------------------------------------
// tb_sdram_sim_model
//
// Directed self-checking bench for sdram_sim_model with default parameters.
// Inputs change on the falling edge. Outputs are sampled on the falling edge,
// half a cycle away from the rising edge where the DUT acts.
// ---------------------------------------------------------------------------
module tb_sdram_sim_model;

  localparam int unsigned MEM_SIZE    = 32'h0001_0000;
  localparam int          READ_LAT    = 4;
  localparam int          WRITE_LAT   = 4;
  localparam int          REFRESH_LAT = 8;

  logic        clk;
  logic        rst;
  logic [31:0] w_addr;
  logic        w_le;
  logic        w_we;
  logic        w_refresh;
  logic [31:0] w_wdata;
  logic [3:0]  w_mask;
  logic        w_stall;
  logic [31:0] w_odata;
  logic [31:0] w_mtime;

  int n_vec;
  int n_err;

  sdram_sim_model #(
    .MEM_SIZE   (MEM_SIZE),
    .READ_LAT   (READ_LAT),
    .WRITE_LAT  (WRITE_LAT),
    .REFRESH_LAT(REFRESH_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .w_addr   (w_addr),
    .w_le     (w_le),
    .w_we     (w_we),
    .w_refresh(w_refresh),
    .w_wdata  (w_wdata),
    .w_mask   (w_mask),
    .w_stall  (w_stall),
    .w_odata  (w_odata),
    .w_mtime  (w_mtime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) w_mtime <= w_mtime + 32'd1;

  // Issue one request and hold it until stall is seen. Then count the falling
  // edges that observe stall high. The task returns on the first falling edge
  // with stall low, where read data is valid. The loop is bounded, so a stuck
  // DUT returns 0 or 64 cycles and fails the caller's cycle check.
  task automatic do_op(input logic we, input logic le, input logic rf,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, output int cycles);
    @(negedge clk);
    w_we = we; w_le = le; w_refresh = rf;
    w_addr = addr; w_wdata = data; w_mask = mask;
    @(posedge clk);
    cycles = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (w_stall) begin
        cycles++;
        w_we = 1'b0; w_le = 1'b0; w_refresh = 1'b0;
      end else begin
        break;
      end
    end
    w_we = 1'b0; w_le = 1'b0; w_refresh = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (w_stall !== 1'b0) begin
      n_err++; $display("FAIL reset_stall got=%b want=0", w_stall);
    end
    n_vec++;
    if (w_odata !== 32'd0) begin
      n_err++; $display("FAIL reset_odata got=%h want=00000000", w_odata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_write_read();
    int cyc;
    do_op(1, 0, 0, 32'h100, 32'hDEAD_BEEF, 4'hF, cyc);
    n_vec++;
    if (cyc !== WRITE_LAT) begin
      n_err++; $display("FAIL write_lat got=%0d want=%0d", cyc, WRITE_LAT);
    end
    do_op(0, 1, 0, 32'h100, 32'h0, 4'h0, cyc);
    n_vec++;
    if (cyc !== READ_LAT) begin
      n_err++; $display("FAIL read_lat got=%0d want=%0d", cyc, READ_LAT);
    end
    n_vec++;
    if (w_odata !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL read_full got=%h want=deadbeef", w_odata);
    end
  endtask

  task automatic test_partial_write();
    int cyc;
    do_op(1, 0, 0, 32'h100, 32'h1122_3344, 4'b0101, cyc);
    do_op(0, 1, 0, 32'h100, 32'h0, 4'h0, cyc);
    n_vec++;
    if (w_odata !== 32'hDE22_BE44) begin
      n_err++; $display("FAIL partial got=%h want=de22be44", w_odata);
    end
  endtask

  task automatic test_addressing();
    int cyc;
    // Low address bits are ignored.
    do_op(0, 1, 0, 32'h103, 32'h0, 4'h0, cyc);
    n_vec++;
    if (w_odata !== 32'hDE22_BE44) begin
      n_err++; $display("FAIL unaligned_read got=%h want=de22be44", w_odata);
    end
    // An address beyond MEM_SIZE wraps onto 0x100.
    do_op(1, 0, 0, MEM_SIZE + 32'h100, 32'h5566_7788, 4'hF, cyc);
    do_op(0, 1, 0, 32'h100, 32'h0, 4'h0, cyc);
    n_vec++;
    if (w_odata !== 32'h5566_7788) begin
      n_err++; $display("FAIL wrap got=%h want=55667788", w_odata);
    end
    // Last word of the store.
    do_op(1, 0, 0, MEM_SIZE - 32'd4, 32'h0BAD_F00D, 4'hF, cyc);
    do_op(0, 1, 0, MEM_SIZE - 32'd1, 32'h0, 4'h0, cyc);
    n_vec++;
    if (w_odata !== 32'h0BAD_F00D) begin
      n_err++; $display("FAIL last_word got=%h want=0badf00d", w_odata);
    end
  endtask

  task automatic test_mask_zero();
    int cyc;
    do_op(1, 0, 0, 32'h100, 32'hFFFF_FFFF, 4'h0, cyc);
    n_vec++;
    if (cyc !== WRITE_LAT) begin
      n_err++; $display("FAIL mask0_lat got=%0d want=%0d", cyc, WRITE_LAT);
    end
    do_op(0, 1, 0, 32'h100, 32'h0, 4'h0, cyc);
    n_vec++;
    if (w_odata !== 32'h5566_7788) begin
      n_err++; $display("FAIL mask0_data got=%h want=55667788", w_odata);
    end
  endtask

  task automatic test_refresh();
    int cyc;
    do_op(1, 0, 0, 32'h200, 32'hA5A5_0F0F, 4'hF, cyc);
    do_op(0, 0, 1, 32'h0, 32'h0, 4'h0, cyc);
    n_vec++;
    if (cyc !== REFRESH_LAT) begin
      n_err++; $display("FAIL refresh_lat got=%0d want=%0d", cyc, REFRESH_LAT);
    end
    n_vec++;
    if (w_odata !== 32'h5566_7788) begin
      n_err++; $display("FAIL refresh_odata got=%h want=55667788", w_odata);
    end

    // Raise a read during refresh. It must wait for IDLE and then be taken.
    @(negedge clk);
    w_refresh = 1'b1;
    @(posedge clk);
    cyc = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (w_stall) begin
        cyc++;
        w_refresh = 1'b0;
        if (cyc == 3) begin
          w_le = 1'b1; w_addr = 32'h200;
        end
      end else begin
        break;
      end
    end
    n_vec++;
    if (cyc !== REFRESH_LAT) begin
      n_err++; $display("FAIL refresh_mid_le_lat got=%0d want=%0d", cyc, REFRESH_LAT);
    end
    n_vec++;
    if (w_odata !== 32'h5566_7788) begin
      n_err++; $display("FAIL refresh_mid_le_odata got=%h want=55667788", w_odata);
    end
    @(posedge clk);
    cyc = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (w_stall) begin
        cyc++;
        w_le = 1'b0;
      end else begin
        break;
      end
    end
    w_le = 1'b0;
    n_vec++;
    if (cyc !== READ_LAT) begin
      n_err++; $display("FAIL deferred_read_lat got=%0d want=%0d", cyc, READ_LAT);
    end
    n_vec++;
    if (w_odata !== 32'hA5A5_0F0F) begin
      n_err++; $display("FAIL deferred_read got=%h want=a5a50f0f", w_odata);
    end
  endtask

  task automatic test_we_le_together();
    int cyc;
    do_op(1, 1, 0, 32'h100, 32'h0102_0304, 4'hF, cyc);
    n_vec++;
    if (cyc !== WRITE_LAT) begin
      n_err++; $display("FAIL we_le_lat got=%0d want=%0d", cyc, WRITE_LAT);
    end
    n_vec++;
    if (w_odata !== 32'hA5A5_0F0F) begin
      n_err++; $display("FAIL we_le_odata got=%h want=a5a50f0f", w_odata);
    end
    do_op(0, 1, 0, 32'h100, 32'h0, 4'h0, cyc);
    n_vec++;
    if (w_odata !== 32'h0102_0304) begin
      n_err++; $display("FAIL we_le_written got=%h want=01020304", w_odata);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    @(negedge clk);
    w_we = 1'b1; w_addr = 32'h100; w_wdata = 32'hCAFE_F00D; w_mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    w_we = 1'b0;
    @(negedge clk);
    n_vec++;
    if (w_stall !== 1'b1) begin
      n_err++; $display("FAIL abort_busy got=%b want=1", w_stall);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (w_stall !== 1'b0) begin
      n_err++; $display("FAIL abort_stall got=%b want=0", w_stall);
    end
    n_vec++;
    if (w_odata !== 32'd0) begin
      n_err++; $display("FAIL abort_odata got=%h want=00000000", w_odata);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 1, 0, 32'h100, 32'h0, 4'h0, cyc);
    n_vec++;
    if (w_odata !== 32'h0102_0304) begin
      n_err++; $display("FAIL abort_mem got=%h want=01020304", w_odata);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; w_addr = 32'd0; w_le = 1'b0; w_we = 1'b0; w_refresh = 1'b0;
    w_wdata = 32'd0; w_mask = 4'd0; w_mtime = 32'd0;
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_addressing();
    test_mask_zero();
    test_refresh();
    test_we_le_together();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
